fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Frame-buffer port controller that shares one single-port synchronous 16-bit RAM between two requesters: the display scan-out path (sequential reads) and the image generator (random-address writes). It prefetches display words into a small show-ahead FIFO, arbitrates each RAM cycle between prefetch reads and generator writes, and drives the RAM port with registered signals. It sits between the image generator, the frame-buffer RAM and the VGA pixel serializer in the 800x480 buffered design.

## Interface
- FB_WORDS, 24000, number of 16-bit words in one frame (800*480/16); valid read addresses are 0..FB_WORDS-1
- FIFO_DEPTH, 8, prefetch FIFO entries, power of two, minimum 4
- LOW_WATER, 4, prefetch level below which reads take priority over writes
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state cleared
- wr_valid  in  1  generator has a write pending
- wr_ready  out  1  write granted this cycle
- wr_addr  in  16  generator word address
- wr_data  in  16  generator pixel word
- disp_start  in  1  one-cycle pulse at frame start; restarts scan-out at word 0
- disp_pop  in  1  serializer consumes the head word
- disp_data  out  16  FIFO head word (show-ahead)
- disp_empty  out  1  FIFO holds no word
- underrun  out  1  sticky: pop seen while empty
- ram_addr  out  16  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  16  RAM write data (registered)
- ram_rdata  in  16  RAM read data, valid one cycle after a read address is presented

## Operation
- Level = FIFO count + reads in flight (0..2). Read pointer rd_ptr counts 0..FB_WORDS-1, wraps to 0 after FB_WORDS-1.
- Per-cycle grant, evaluated combinationally from registered state:
  - level < LOW_WATER: grant READ (a write, if valid, waits; wr_ready=0).
  - else wr_valid=1: grant WRITE (wr_ready=1).
  - else level < FIFO_DEPTH: grant READ.
  - else: IDLE.
- READ grant: at the edge, ram_addr<=rd_ptr, ram_we<=0, rd_ptr advances, in-flight tag set.
- WRITE grant (wr_valid&wr_ready): at the edge, ram_addr<=wr_addr, ram_wdata<=wr_data, ram_we<=1. wr_addr>=FB_WORDS: handshake completes, ram_we stays 0 (write dropped).
- IDLE: ram_we<=0, ram_addr/ram_wdata hold.
- Return path: ram_rdata for a tagged read is pushed into the FIFO at the edge ending the cycle it is valid. The level rule guarantees the FIFO never overflows.
- disp_pop with disp_empty=0 removes the head at the edge. disp_pop with disp_empty=1 sets underrun; FIFO is unchanged.
- disp_start: FIFO flushed, rd_ptr<=0, in-flight tags invalidated (their data is discarded), underrun cleared. A write granted in the same cycle still completes. A READ is not granted in the disp_start cycle. disp_pop in the same cycle is ignored.
- Push and pop in the same cycle: count unchanged, head advances.

## Timing
- Reset values: wr_ready=0 while level<LOW_WATER (i.e. 0 out of reset), disp_data=0, disp_empty=1, underrun=0, ram_addr=0, ram_we=0, ram_wdata=0, rd_ptr=0.
- Read latency: grant edge N -> ram_addr at cycle N+1 -> ram_rdata at N+2 -> disp_data valid, disp_empty=0 at N+3.
- Write latency: handshake edge -> ram_we=1 with address/data for exactly one cycle after it.
- After reset or disp_start with no writes, reads are granted every cycle until level=FIFO_DEPTH. The first word is visible 3 cycles after the first grant.
- Throughput: one RAM access per cycle. Sustained write rate with one pop every 16 cycles is at least 15/16.
- Reset asserted mid-operation: all outputs return to reset values immediately; in-flight data is lost.

## Test plan
- Reset, wr_valid=0, RAM preloaded word[i]=i: disp_empty falls 3 cycles after the first grant. Pops return 0,1,2…7. ram_we stays 0, and no more than 8 reads issue before the first pop.
- FIFO full, wr_valid=1 held, wr_addr=5, wr_data=16'hA5A5: wr_ready=1 every cycle. ram_we=1, ram_addr=5, ram_wdata=A5A5 one cycle after each handshake.
- FIFO full, continuous writes, then pop 5 words (level 3): the next cycle grants READ with wr_ready=0. Writes resume once level reaches 4.
- Read wrap: with FB_WORDS=24000, pops across the boundary return words 23999 then 0.
- disp_start while 2 reads are in flight: disp_empty=1 next cycle. The discarded data never appears. The first popped word is word 0; underrun=0.
- disp_pop while empty: underrun=1 and stays set until disp_start. Write to wr_addr=24000 completes its handshake with ram_we=0.

Source files
------------

// File: rtl/fb_arbiter.sv
// Frame-buffer port controller: one single-port RAM shared between display
// prefetch reads (show-ahead FIFO) and image-generator writes.
module fb_arbiter #(
  parameter int FB_WORDS   = 24000,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        disp_start,
  input  logic        disp_pop,
  output logic [15:0] disp_data,
  output logic        disp_empty,
  output logic        underrun,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = AW + 2;
  localparam logic [15:0]   LAST_ADDR = 16'(FB_WORDS - 1);
  localparam logic [15:0]   FB_LIMIT  = 16'(FB_WORDS);
  localparam logic [LW-1:0] LOW_LVL   = LW'(LOW_WATER);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_t;

  logic [15:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [15:0]   rd_ptr_r;
  logic          tag1_r;
  logic          tag2_r;
  logic          underrun_r;
  logic [15:0]   ram_addr_r;
  logic          ram_we_r;
  logic [15:0]   ram_wdata_r;

  logic [LW-1:0] level_s;
  grant_t        grant_s;
  logic          rd_fire_s;
  logic          wr_in_range_s;
  logic          push_s;
  logic          pop_s;
  logic          pop_empty_s;

  // Occupancy seen by the arbiter: stored words plus reads still in the RAM pipe.
  assign level_s = LW'(count_r) + LW'(tag1_r) + LW'(tag2_r);

  // Grant selection; reads win below the low-water mark so scan-out never starves.
  always_comb begin
    grant_s = GNT_IDLE;
    if (level_s < LOW_LVL) begin
      grant_s = GNT_READ;
    end else if (wr_valid) begin
      grant_s = GNT_WRITE;
    end else if (level_s < FULL_LVL) begin
      grant_s = GNT_READ;
    end else begin
      grant_s = GNT_IDLE;
    end
  end

  // A frame restart suppresses the read so the new scan begins cleanly at word 0.
  assign rd_fire_s     = (grant_s == GNT_READ) && !disp_start;
  assign wr_in_range_s = (wr_addr < FB_LIMIT);
  assign push_s        = tag2_r && !disp_start;
  assign pop_s         = disp_pop && (count_r != CNT_ZERO) && !disp_start;
  assign pop_empty_s   = disp_pop && (count_r == CNT_ZERO) && !disp_start;

  // Prefetch storage, written at the tail when returning read data lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 16'h0000;
      end
    end else if (push_s) begin
      fifo_mem_r[tail_r] <= ram_rdata;
    end
  end

  // FIFO pointers, occupancy and the sticky underrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= CNT_ZERO;
      underrun_r <= 1'b0;
    end else if (disp_start) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= CNT_ZERO;
      underrun_r <= 1'b0;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (pop_empty_s) begin
        underrun_r <= 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Scan-out address and the two-stage in-flight read tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= 16'h0000;
      tag1_r   <= 1'b0;
      tag2_r   <= 1'b0;
    end else if (disp_start) begin
      rd_ptr_r <= 16'h0000;
      tag1_r   <= 1'b0;
      tag2_r   <= 1'b0;
    end else begin
      tag1_r <= rd_fire_s;
      tag2_r <= tag1_r;
      if (rd_fire_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_ADDR) ? 16'h0000 : rd_ptr_r + 16'h0001;
      end
    end
  end

  // Registered RAM port; out-of-range writes handshake but never assert ram_we.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr_r  <= 16'h0000;
      ram_we_r    <= 1'b0;
      ram_wdata_r <= 16'h0000;
    end else begin
      case (grant_s)
        GNT_READ: begin
          ram_we_r <= 1'b0;
          if (rd_fire_s) begin
            ram_addr_r <= rd_ptr_r;
          end
        end
        GNT_WRITE: begin
          if (wr_in_range_s) begin
            ram_addr_r  <= wr_addr;
            ram_wdata_r <= wr_data;
            ram_we_r    <= 1'b1;
          end else begin
            ram_we_r <= 1'b0;
          end
        end
        default: ram_we_r <= 1'b0;
      endcase
    end
  end

  assign wr_ready   = (grant_s == GNT_WRITE);
  assign disp_data  = fifo_mem_r[head_r];
  assign disp_empty = (count_r == CNT_ZERO);
  assign underrun   = underrun_r;
  assign ram_addr   = ram_addr_r;
  assign ram_we     = ram_we_r;
  assign ram_wdata  = ram_wdata_r;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural RAM and queue scoreboards
// for display words and RAM write transactions.
module tb_fb_arbiter;

  localparam int FBW = 24000;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        disp_start;
  logic        disp_pop;
  logic [15:0] disp_data;
  logic        disp_empty;
  logic        underrun;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  fb_arbiter #(.FB_WORDS(FBW), .FIFO_DEPTH(8), .LOW_WATER(4)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_start(disp_start), .disp_pop(disp_pop), .disp_data(disp_data),
    .disp_empty(disp_empty), .underrun(underrun),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, preloaded with word[i] = i while reset is high.
  logic [15:0] ram_mem [0:FBW-1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FBW; i++) ram_mem[i] <= i[15:0];
    end else if (ram_we && ram_addr < 16'd24000) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= (ram_addr < 16'd24000) ? ram_mem[ram_addr] : 16'h0000;
  end

  typedef struct packed { logic we; logic [15:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [15:0] a; logic [15:0] d; } rd_t;

  int          checks = 0;
  int          errors = 0;
  int          exp_ptr;
  logic [15:0] ref_mem [0:FBW-1];
  wr_t         wq[$];
  rd_t         dq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int n);
    rd_t e;
    for (int i = 0; i < n; i++) begin
      e.a = exp_ptr[15:0];
      e.d = ref_mem[exp_ptr];
      dq.push_back(e);
      exp_ptr = (exp_ptr == FBW - 1) ? 0 : exp_ptr + 1;
    end
  endtask

  // One clock cycle: drive, check combinational/head outputs, then RAM port after the edge.
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                       input logic p, input logic pe, input logic s, input int exp_rdy);
    logic hs;
    wr_t  w;
    rd_t  e;
    wr_valid = v; wr_addr = a; wr_data = d; disp_pop = p | pe; disp_start = s;
    #1;
    if (exp_rdy >= 0) chk("wr_ready", {31'd0, wr_ready}, exp_rdy);
    hs = v & wr_ready;
    if (hs) begin
      w.we = (a < 16'd24000);
      w.a  = a;
      w.d  = d;
      wq.push_back(w);
      if (a < 16'd24000) ref_mem[a] = d;
    end
    if (p && !s) begin
      if (dq.size() == 0) push_exp(1);
      e = dq.pop_front();
      chk("pop_nonempty", {31'd0, disp_empty}, 32'd0);
      chk("disp_data", {16'd0, disp_data}, {16'd0, e.d});
      if (e.a == 16'd23999) chk("wrap_last", {16'd0, disp_data}, 32'd23999);
      if (e.a == 16'd0) chk("word0", {16'd0, disp_data}, 32'd0);
    end
    if (pe) chk("pop_empty", {31'd0, disp_empty}, 32'd1);
    @(posedge clk);
    #1;
    if (hs) begin
      w = wq.pop_front();
      chk("ram_we", {31'd0, ram_we}, {31'd0, w.we});
      if (w.we) begin
        chk("ram_addr_wr", {16'd0, ram_addr}, {16'd0, w.a});
        chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, w.d});
      end
    end else begin
      chk("ram_we_idle", {31'd0, ram_we}, 32'd0);
    end
    wr_valid = 1'b0; disp_pop = 1'b0; disp_start = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic pop1();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic do_start();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, -1);
    dq.delete();
    exp_ptr = 0;
  endtask

  initial begin
    logic [15:0] rnd;
    reset = 1'b1; wr_valid = 1'b0; wr_addr = 16'h0000; wr_data = 16'h0000;
    disp_pop = 1'b0; disp_start = 1'b0;
    for (int i = 0; i < FBW; i++) ref_mem[i] = i[15:0];
    exp_ptr = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    wr_valid = 1'b1;
    #1;
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_disp_empty", {31'd0, disp_empty}, 32'd1);
    chk("rst_disp_data", {16'd0, disp_data}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(8);

    // Prefetch after reset: first word visible three edges after the first grant
    idle();
    chk("pf_addr0", {16'd0, ram_addr}, 32'd0);
    chk("pf_empty1", {31'd0, disp_empty}, 32'd1);
    idle();
    chk("pf_addr1", {16'd0, ram_addr}, 32'd1);
    chk("pf_empty2", {31'd0, disp_empty}, 32'd1);
    idle();
    chk("pf_empty3", {31'd0, disp_empty}, 32'd0);
    chk("pf_head", {16'd0, disp_data}, 32'd0);
    repeat (15) idle();
    chk("pf_last_addr", {16'd0, ram_addr}, 32'd7);
    chk("pf_full_nonempty", {31'd0, disp_empty}, 32'd0);

    // FIFO full: writes granted every cycle
    repeat (4) drive(1'b1, 16'd5, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1);

    // Pop five with writes pending, then one read cycle, then writes resume
    for (int k = 0; k < 5; k++) begin
      rnd = 16'($urandom);
      drive(1'b1, 16'(100 + k), rnd, 1'b1, 1'b0, 1'b0, 1);
    end
    drive(1'b1, 16'd110, 16'h1234, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      rnd = 16'($urandom);
      drive(1'b1, 16'(110 + k), rnd, 1'b0, 1'b0, 1'b0, 1);
    end
    repeat (10) idle();

    // Continuous scan across the end of the frame and back into rewritten words
    for (int k = 0; k < FBW + 3; k++) pop1();

    // Restart with two reads in flight
    do_start();
    chk("st_empty", {31'd0, disp_empty}, 32'd1);
    chk("st_underrun", {31'd0, underrun}, 32'd0);
    idle();
    chk("st_addr0", {16'd0, ram_addr}, 32'd0);
    chk("st_empty1", {31'd0, disp_empty}, 32'd1);
    idle();
    chk("st_empty2", {31'd0, disp_empty}, 32'd1);
    idle();
    chk("st_empty3", {31'd0, disp_empty}, 32'd0);
    chk("st_head", {16'd0, disp_data}, 32'd0);
    repeat (4) pop1();
    chk("st_underrun_after", {31'd0, underrun}, 32'd0);

    // Underrun is sticky until the next restart; out-of-range write is dropped
    repeat (8) idle();
    do_start();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, -1);
    chk("ur_set", {31'd0, underrun}, 32'd1);
    repeat (12) idle();
    chk("ur_hold", {31'd0, underrun}, 32'd1);
    drive(1'b1, 16'd24000, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1);
    repeat (3) pop1();
    chk("ur_hold2", {31'd0, underrun}, 32'd1);
    do_start();
    chk("ur_clear", {31'd0, underrun}, 32'd0);

    // Reset mid-operation returns outputs to reset values at once
    repeat (4) idle();
    reset = 1'b1;
    #1;
    chk("mr_empty", {31'd0, disp_empty}, 32'd1);
    chk("mr_data", {16'd0, disp_data}, 32'd0);
    chk("mr_addr", {16'd0, ram_addr}, 32'd0);
    chk("mr_we", {31'd0, ram_we}, 32'd0);
    chk("mr_wdata", {16'd0, ram_wdata}, 32'd0);
    chk("mr_underrun", {31'd0, underrun}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
